seg7_scan_decoder: RTL

SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

---
 rtl/seg7_pkg.sv | 34 +++
 rtl/seg7_pattern_decode.sv | 33 +++
 rtl/seg7_scan_decoder.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan decoder: segment patterns, FSM states, slot indices.
// Latency: n/a (package). Backpressure: n/a.
package seg7_pkg;

    // Segment bit order is {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_MINUS = 7'h40;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_HOLD
    } state_t;

    localparam int SLOT_ONES = 0;
    localparam int SLOT_TENS = 1;
    localparam int SLOT_SIGN = 2;

    function automatic logic is_onehot3(input logic [2:0] a);
        return (a == 3'b001) || (a == 3'b010) || (a == 3'b100);
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Classifies a raw segment pattern as a digit 0-9, blank or minus.
// Latency: combinational. Backpressure: none.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] digit,
    output logic       is_digit,
    output logic       is_blank,
    output logic       is_minus
);

    always_comb begin
        digit    = 4'd0;
        is_digit = 1'b1;
        case (seg)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: is_digit = 1'b0;
        endcase
        is_blank = (seg == SEG_BLANK);
        is_minus = (seg == SEG_MINUS);
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers a signed 2-digit number from a multiplexed 3-digit 7-segment scan; confirms on two equal frames.
// Latency: valid/err 1 clk after frame completion / fault detection. Backpressure: none, scan is sampled as it comes.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int SETTLE   = 4,
    parameter int MAX_SLOT = 1023
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] an,
    input  logic [6:0] seg,
    input  logic       dp,
    output logic [7:0] value,
    output logic       valid,
    output logic       err
);

    localparam int            CW         = $clog2(MAX_SLOT + 2);
    localparam logic [CW-1:0] CNT_SETTLE = CW'(SETTLE);
    localparam logic [CW-1:0] CNT_TMO    = CW'(MAX_SLOT);
    localparam logic [CW-1:0] CNT_SAT    = CW'(MAX_SLOT + 1);

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt, cnt_inc;
    logic [2:0]      an_q;
    logic            multi, multi_q, an_chg, an_ld;
    logic            capture, err_pat, err_tmo, err_now, clear_all, complete;
    logic            slot_ok;
    logic [2:0]      flags;
    logic            neg_q;
    logic [3:0]      tens_q, ones_q;
    logic [7:0]      prev_q, mag, frame_val;
    logic            prev_vld;
    logic [3:0]      digit;
    logic            is_digit, is_blank, is_minus;

    seg7_pattern_decode u_dec (
        .seg      (seg),
        .digit    (digit),
        .is_digit (is_digit),
        .is_blank (is_blank),
        .is_minus (is_minus)
    );

    assign multi   = (an != 3'b000) && !is_onehot3(an);
    assign an_chg  = (an != an_q);
    assign cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + CW'(1);

    always_comb begin
        slot_ok = 1'b0;
        if (an_q[SLOT_SIGN])      slot_ok = is_blank | is_minus;
        else if (an_q[SLOT_TENS]) slot_ok = is_digit | is_blank;
        else if (an_q[SLOT_ONES]) slot_ok = is_digit;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        an_ld     = 1'b0;
        capture   = 1'b0;
        err_pat   = 1'b0;
        err_tmo   = 1'b0;
        if (multi) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (an != 3'b000) begin
                        state_nxt = ST_SETTLE;
                        cnt_nxt   = CW'(1);
                        an_ld     = 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (an_chg) begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_TMO) begin
                        // Park in HOLD with a saturated count so the timeout reports once
                        err_tmo   = 1'b1;
                        state_nxt = ST_HOLD;
                        cnt_nxt   = CNT_SAT;
                    end else begin
                        if (cnt >= CNT_SETTLE) state_nxt = ST_SAMPLE;
                        cnt_nxt = cnt_inc;
                    end
                end
                ST_SAMPLE: begin
                    cnt_nxt = cnt_inc;
                    if (!slot_ok || dp) begin
                        err_pat   = 1'b1;
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        capture   = 1'b1;
                        state_nxt = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (an_chg) begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_TMO) begin
                        err_tmo = 1'b1;
                        cnt_nxt = CNT_SAT;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    assign err_now   = (multi & ~multi_q) | err_pat | err_tmo;
    assign clear_all = multi | err_pat | err_tmo;
    assign complete  = (flags == 3'b111) && !clear_all;
    assign mag       = 8'(tens_q) * 8'd10 + 8'(ones_q);
    assign frame_val = neg_q ? (8'd0 - mag) : mag;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            an_q     <= 3'b000;
            multi_q  <= 1'b0;
            flags    <= 3'b000;
            neg_q    <= 1'b0;
            tens_q   <= 4'd0;
            ones_q   <= 4'd0;
            prev_q   <= 8'd0;
            prev_vld <= 1'b0;
            value    <= 8'd0;
            valid    <= 1'b0;
            err      <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            multi_q <= multi;
            valid   <= 1'b0;
            err     <= err_now;
            if (an_ld) an_q <= an;
            if (clear_all) begin
                flags    <= 3'b000;
                neg_q    <= 1'b0;
                tens_q   <= 4'd0;
                ones_q   <= 4'd0;
                prev_q   <= 8'd0;
                prev_vld <= 1'b0;
            end else begin
                flags <= (complete ? 3'b000 : flags) | (capture ? an_q : 3'b000);
                if (complete) begin
                    prev_q   <= frame_val;
                    prev_vld <= 1'b1;
                    if (prev_vld && prev_q == frame_val) begin
                        value <= frame_val;
                        valid <= 1'b1;
                    end
                end
                if (capture) begin
                    if (an_q[SLOT_SIGN])      neg_q  <= is_minus;
                    else if (an_q[SLOT_TENS]) tens_q <= digit;
                    else                      ones_q <= digit;
                end
            end
        end
    end

endmodule
